karatsuba_mul_seq: RTL and testbench

Parametrised, sequential successor to the combinational 256-bit Karatsuba multiplier. Computes the full unsigned product C = A*B for W-bit operands using one shared (W/2+1)x(W/2+1) multiplier over three cycles: three Karatsuba partial products instead of four. A valid/ready handshake sits on both input and output, so the block drops into streaming datapaths where the flat multiplier's area is unaffordable.

---
 rtl/karatsuba_mul_seq.sv | 183 ++++++++++++++++++
 tb/tb_karatsuba_mul_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_mul_seq.sv
// Sequential W x W unsigned multiplier: three Karatsuba partial products share one
// (W/2+1)-bit multiplier, with valid/ready handshakes on both operand and product sides.
module karatsuba_mul_seq #(
  parameter int W = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] C,
  output logic           busy
);

  localparam int H  = W / 2;
  localparam int PW = 2 * H + 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL0 = 3'd1,
    ST_MUL1 = 3'd2,
    ST_MUL2 = 3'd3,
    ST_COMB = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic           in_ready_r;
  logic           busy_r;
  logic           out_valid_r;
  logic           in_ready_s;
  logic           busy_s;
  logic           out_valid_s;
  logic [H-1:0]   a0_r;
  logic [H-1:0]   a1_r;
  logic [H-1:0]   b0_r;
  logic [H-1:0]   b1_r;
  logic [PW-1:0]  p0_r;
  logic [PW-1:0]  p2_r;
  logic [PW-1:0]  pm_r;
  logic [H:0]     mul_a_s;
  logic [H:0]     mul_b_s;
  logic [PW-1:0]  mul_p_s;
  logic [PW-1:0]  mid_s;
  logic [2*W-1:0] c_sum_s;
  logic [2*W-1:0] c_r;

  // State register and registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= in_ready_s;
      busy_r      <= busy_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_MUL0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL0: state_next_s = ST_MUL1;
      ST_MUL1: state_next_s = ST_MUL2;
      ST_MUL2: state_next_s = ST_COMB;
      ST_COMB: state_next_s = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered flags track state_r exactly
  always_comb begin
    in_ready_s  = 1'b0;
    busy_s      = 1'b1;
    out_valid_s = 1'b0;
    case (state_next_s)
      ST_IDLE: begin
        in_ready_s  = 1'b1;
        busy_s      = 1'b0;
        out_valid_s = 1'b0;
      end
      ST_DONE: begin
        in_ready_s  = 1'b0;
        busy_s      = 1'b1;
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b0;
        busy_s      = 1'b1;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Shared multiplier operand select; MUL2 feeds the carry-preserving half sums
  always_comb begin
    mul_a_s = '0;
    mul_b_s = '0;
    case (state_r)
      ST_MUL0: begin
        mul_a_s = {1'b0, a0_r};
        mul_b_s = {1'b0, b0_r};
      end
      ST_MUL1: begin
        mul_a_s = {1'b0, a1_r};
        mul_b_s = {1'b0, b1_r};
      end
      ST_MUL2: begin
        mul_a_s = {1'b0, a0_r} + {1'b0, a1_r};
        mul_b_s = {1'b0, b0_r} + {1'b0, b1_r};
      end
      default: begin
        mul_a_s = '0;
        mul_b_s = '0;
      end
    endcase
  end

  assign mul_p_s = {{(H + 1){1'b0}}, mul_a_s} * {{(H + 1){1'b0}}, mul_b_s};
  assign mid_s   = pm_r - p0_r - p2_r;
  // Summing modulo 2^(2W) yields the same low bits as the full-width sum, which is all C keeps
  assign c_sum_s = {{(W - 2){1'b0}}, p0_r}
                 + ({{(W - 2){1'b0}}, mid_s} << H)
                 + ({{(W - 2){1'b0}}, p2_r} << W);

  // Operand capture, partial-product registers and the product register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_r <= '0;
      a1_r <= '0;
      b0_r <= '0;
      b1_r <= '0;
      p0_r <= '0;
      p2_r <= '0;
      pm_r <= '0;
      c_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a0_r <= A[H-1:0];
            a1_r <= A[W-1:H];
            b0_r <= B[H-1:0];
            b1_r <= B[W-1:H];
          end
        end
        ST_MUL0: p0_r <= mul_p_s;
        ST_MUL1: p2_r <= mul_p_s;
        ST_MUL2: pm_r <= mul_p_s;
        ST_COMB: c_r  <= c_sum_s;
        default: c_r  <= c_r;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign C         = c_r;

endmodule

// File: tb/tb_karatsuba_mul_seq.sv
// Scoreboard bench for karatsuba_mul_seq: instances at W = 4, 8, 16, 64, 128 and 256 share
// one operand bus; the selected instance is driven and its outputs are checked by a monitor.
module tb_karatsuba_mul_seq;

  localparam int NI = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [255:0] a_bus;
  logic [255:0] b_bus;
  int           sel;

  logic [511:0] c_arr    [NI];
  logic         ov_arr   [NI];
  logic         ir_arr   [NI];
  logic         busy_arr [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WI = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 16 :
                        (g == 3) ? 64 : (g == 4) ? 128 : 256;
    logic [2*WI-1:0] c_w;
    logic            iv_w;
    assign iv_w = in_valid && (sel == g);
    karatsuba_mul_seq #(.W(WI)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv_w),
      .in_ready  (ir_arr[g]),
      .A         (a_bus[WI-1:0]),
      .B         (b_bus[WI-1:0]),
      .out_valid (ov_arr[g]),
      .out_ready (out_ready),
      .C         (c_w),
      .busy      (busy_arr[g])
    );
    assign c_arr[g] = 512'(c_w);
  end

  logic [511:0] c_m;
  logic         ov_m;
  logic         ir_m;
  logic         busy_m;
  always_comb begin
    c_m    = c_arr[sel];
    ov_m   = ov_arr[sel];
    ir_m   = ir_arr[sel];
    busy_m = busy_arr[sel];
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [511:0] exp_q [$];
  int           acc_q [$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (sel=%0d): got %0h expected %0h", name, sel, act, exp);
    end
  endtask

  function automatic logic [255:0] mask_w(input int w);
    if (w >= 256) return '1;
    else return (256'd1 << w) - 256'd1;
  endfunction

  function automatic int w_of(input int i);
    case (i)
      0: return 4;
      1: return 8;
      2: return 16;
      3: return 64;
      4: return 128;
      default: return 256;
    endcase
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  // Monitor: product/latency/stability/handshake checks, sampled on the falling edge
  logic         ov_prev = 1'b0;
  logic         hs_prev = 1'b0;
  logic [511:0] held_c  = '0;
  always @(negedge clk) begin
    if (rst) begin
      ov_prev <= 1'b0;
      hs_prev <= 1'b0;
    end else begin
      chk("ready_vs_busy", 512'(ir_m), 512'(!busy_m));
      if (hs_prev) begin
        chk("ready_after_handshake", 512'(ir_m), 512'(1));
        chk("valid_dropped", 512'(ov_m), 512'(0));
      end
      if (ov_m && !ov_prev) begin
        if (acc_q.size() == 0) chk("spurious_valid", 512'(ov_m), 512'(0));
        else chk("latency", 512'(cyc - acc_q.pop_front()), 512'(4));
      end
      if (ov_m && ov_prev) chk("stable_c", c_m, held_c);
      if (ov_m && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 512'(ov_m), 512'(0));
        else chk("product", c_m, exp_q.pop_front());
      end
      ov_prev <= ov_m;
      hs_prev <= ov_m && out_ready;
      held_c  <= c_m;
    end
  end

  // One transaction: junk stays on A/B with in_valid high while busy and must never be accepted
  task automatic xact(input logic [255:0] a, input logic [255:0] b, input logic [511:0] exp,
                      input int stall, input bit hold_ready);
    int n;
    a_bus     = a;
    b_bus     = b;
    in_valid  = 1'b1;
    out_ready = hold_ready;
    n = 0;
    while (!ir_m && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept_wait", 512'(ir_m), 512'(1));
    exp_q.push_back(exp);
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    a_bus = ~a;
    b_bus = b ^ 256'd1;
    n = 0;
    while (!ov_m && n < 20) begin @(posedge clk); #1; n++; end
    chk("valid_wait", 512'(ov_m), 512'(1));
    in_valid = 1'b0;
    if (!hold_ready) begin
      repeat (stall) begin @(posedge clk); #1; end
      out_ready = 1'b1;
    end
    n = 0;
    while (ov_m && n < 5) begin @(posedge clk); #1; n++; end
    out_ready = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n;
    int           t1;
    int           t2;
    logic [255:0] ra;
    logic [255:0] rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_bus = '0; b_bus = '0; sel = 0;
    #1;
    for (int i = 0; i < NI; i++) begin
      sel = i; #1;
      chk("reset_c", c_m, 512'd0);
      chk("reset_out_valid", 512'(ov_m), 512'(0));
      chk("reset_in_ready", 512'(ir_m), 512'(1));
      chk("reset_busy", 512'(busy_m), 512'(0));
    end
    sel = 1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // W=8 all-ones, downstream always ready
    xact(256'hFF, 256'hFF, 512'hFE01, 0, 1'b1);

    // Abort during MUL1: reset must wipe the previous product immediately
    a_bus = 256'hAB; b_bus = 256'hCD; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1; #1;
    chk("abort_c", c_m, 512'd0);
    chk("abort_out_valid", 512'(ov_m), 512'(0));
    chk("abort_in_ready", 512'(ir_m), 512'(1));
    chk("abort_busy", 512'(busy_m), 512'(0));
    exp_q.delete(); acc_q.delete();
    @(posedge clk); #1; rst = 1'b0;
    xact(256'd2, 256'd3, 512'd6, 2, 1'b0);

    // Back-to-back accepts with in_valid held high
    out_ready = 1'b1; in_valid = 1'b1; a_bus = 256'd3; b_bus = 256'd5;
    exp_q.push_back(512'd15); t1 = cyc + 1; acc_q.push_back(t1);
    @(posedge clk); #1;
    a_bus = 256'd7; b_bus = 256'd11;
    n = 0;
    while (!ir_m && n < 20) begin @(posedge clk); #1; n++; end
    exp_q.push_back(512'd77); t2 = cyc + 1; acc_q.push_back(t2);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("b2b_spacing", 512'(t2 - t1), 512'(6));
    repeat (8) begin @(posedge clk); #1; end
    out_ready = 1'b0;

    // W=256 directed corners: carries out of both half sums, zero and identity
    sel = 5;
    xact('1, '1, {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1}, 3, 1'b0);
    rb = rand256();
    xact(256'd0, rb, 512'd0, 1, 1'b0);
    rb = rand256();
    xact(256'd1, rb, 512'(rb), 0, 1'b0);

    // W=256 random pairs with random output stalls
    for (int i = 0; i < 1000; i++) begin
      ra = rand256();
      rb = rand256();
      xact(ra, rb, 512'(ra) * 512'(rb), int'($urandom_range(0, 10)), 1'b0);
    end

    // Parameter sweep over the remaining widths
    for (int s = 0; s < 5; s++) begin
      if (s != 1) begin
        sel = s;
        for (int i = 0; i < 20; i++) begin
          ra = rand256() & mask_w(w_of(s));
          rb = rand256() & mask_w(w_of(s));
          xact(ra, rb, 512'(ra) * 512'(rb), int'($urandom_range(0, 3)), 1'b0);
        end
      end
    end

    repeat (10) begin @(posedge clk); #1; end
    chk("scoreboard_drained", 512'(exp_q.size()), 512'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
